// File: rtl/bus_arbiter_pkg.sv
// Shared types for the IF/MEM bus arbiter: FSM encoding, grant owner, and
// the fixed byte-enable used for instruction fetches.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DBUSY = 2'd1,
    ARB_IBUSY = 2'd2,
    ARB_IDROP = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [3:0] SEL_WORD = 4'hF;

  function automatic logic is_busy(input arb_state_t s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Busy-cycle watchdog: pulses timeout in the TIMEOUT_CYC-th busy cycle after
// a grant when no bus ack arrives in that cycle.
module bus_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  input  logic ack,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stuck count cannot wrap before the next grant clears it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (busy && cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout = busy & ~ack & (cnt == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and
// data access; data wins ties unless it won the previous grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_sel_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  input  logic              flush_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  arb_state_t        state, state_d;
  grant_t            last_grant;
  logic              grant_d, grant_i;
  logic              d_req, i_req;
  logic              timeout, done;
  logic              if_ack_d, dm_ack_d;
  logic [DATA_W-1:0] if_data_d, dm_rdata_d;

  // A requester whose ack is on the outputs this cycle still holds a stale level.
  assign d_req = dm_req_i & ~dm_ack_o;
  assign i_req = if_req_i & ~if_ack_o & ~flush_i;
  assign done  = bus_ack_i | timeout;

  bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_d | grant_i),
    .busy    (is_busy(state)),
    .ack     (bus_ack_i),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_D;
    end else begin
      state <= state_d;
      if (grant_d) begin
        last_grant <= GRANT_D;
      end else if (grant_i) begin
        last_grant <= GRANT_I;
      end
    end
  end

  always_comb begin
    state_d = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && (!i_req || last_grant == GRANT_I)) begin
          state_d = ARB_DBUSY;
          grant_d = 1'b1;
        end else if (i_req) begin
          state_d = ARB_IBUSY;
          grant_i = 1'b1;
        end
      end
      ARB_DBUSY: if (done) state_d = ARB_IDLE;
      ARB_IBUSY: begin
        if (done) begin
          state_d = ARB_IDLE;
        end else if (flush_i) begin
          state_d = ARB_IDROP;
        end
      end
      ARB_IDROP: if (done) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Aborted transactions still complete to the requester, with zero data.
  always_comb begin
    bus_cyc_o      = is_busy(state);
    stallreq_mem_o = ~rst & dm_req_i & ~dm_ack_o;
    stallreq_if_o  = ~rst & if_req_i & ~if_ack_o;
    dm_ack_d       = (state == ARB_DBUSY) & done;
    if_ack_d       = (state == ARB_IBUSY) & done & ~flush_i;
    dm_rdata_d     = (dm_ack_d && bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
    if_data_d      = (if_ack_d && bus_ack_i) ? bus_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_data_o   <= '0;
      dm_rdata_o  <= '0;
      bus_err_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      if_ack_o   <= if_ack_d;
      dm_ack_o   <= dm_ack_d;
      if_data_o  <= if_data_d;
      dm_rdata_o <= dm_rdata_d;
      bus_err_o  <= bus_err_o | timeout;
      if (grant_d) begin
        bus_we_o    <= dm_we_i;
        bus_sel_o   <= dm_sel_i;
        bus_addr_o  <= dm_addr_i;
        bus_wdata_o <= dm_wdata_i;
      end else if (grant_i) begin
        bus_we_o    <= 1'b0;
        bus_sel_o   <= SEL_WORD;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle-exact vectors with hand-computed
// expectations, a simple bus responder and a request-protocol checker.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [3:0]  dm_sel_i = 4'hF;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        flush_i = 1'b0;
  logic        stallreq_if_o, stallreq_mem_o;
  logic        bus_cyc_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 0;
  bit mem_hang = 1'b0;
  int cyc_cnt  = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .flush_i(flush_i), .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o)
  );

  // ---------------- clock / global time limit ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0004: return 32'h2401_0005;
      32'h0000_0100: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus_rdata_i = mem_rd(bus_addr_o);

  // Acks in the (mem_wait+1)-th cycle of bus_cyc_o unless hung.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_cyc_o) begin
        bus_ack_i = !mem_hang && (cyc_cnt == mem_wait);
        cyc_cnt++;
      end else begin
        bus_ack_i = 1'b0;
        cyc_cnt = 0;
      end
    end
  end

  // ---------------- request protocol checker ----------------
  logic if_req_q = 1'b0, dm_req_q = 1'b0, if_seen = 1'b1, dm_seen = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      if_seen = 1'b1;
      dm_seen = 1'b1;
    end else begin
      if (dm_req_q && !dm_req_i)
        assert (dm_seen) else $error("protocol: dm_req_i dropped before dm_ack_o");
      if (if_req_q && !if_req_i)
        assert (if_seen || flush_i) else $error("protocol: if_req_i dropped before if_ack_o without flush");
      if (dm_ack_o) dm_seen = 1'b1;
      else if (dm_req_i && !dm_req_q) dm_seen = 1'b0;
      if (if_ack_o) if_seen = 1'b1;
      else if (if_req_i && !if_req_q) if_seen = 1'b0;
    end
    if_req_q = if_req_i;
    dm_req_q = dm_req_i;
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset: stalls forced low during rst, all outputs zero.
    next_cyc(); rst = 1'b1; if_req_i = 1'b1; dm_req_i = 1'b1; smp();
    check("rst_stall", {stallreq_if_o, stallreq_mem_o}, 2'b00);
    next_cyc(); if_req_i = 1'b0; dm_req_i = 1'b0; smp();
    check("rst_outs", {bus_cyc_o, if_ack_o, dm_ack_o, bus_err_o, bus_we_o, bus_sel_o}, 9'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    next_cyc(); rst = 1'b0; smp();
    check("rst_idle_cyc", bus_cyc_o, 1'b0);

    // IF only, zero-wait memory.
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'h4; mem_wait = 0; smp();
    check("if_n_stall", stallreq_if_o, 1'b1);
    check("if_n_cyc", bus_cyc_o, 1'b0);
    next_cyc(); smp();
    check("if_n1_cyc", bus_cyc_o, 1'b1);
    check("if_n1_addr", bus_addr_o, 32'h4);
    check("if_n1_we_sel", {bus_we_o, bus_sel_o}, 5'b0_1111);
    check("if_n1_stall", stallreq_if_o, 1'b1);
    next_cyc(); smp();
    check("if_n2_ack", if_ack_o, 1'b1);
    check("if_n2_data", if_data_o, 32'h2401_0005);
    check("if_n2_stall", stallreq_if_o, 1'b0);
    check("if_n2_cyc", bus_cyc_o, 1'b0);
    next_cyc(); if_req_i = 1'b0; smp();
    check("if_no_regrant", {bus_cyc_o, if_ack_o}, 2'b00);

    // Simultaneous requests after an IF grant: D first, IF right after dm_ack_o.
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'h8;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h100; mem_wait = 3; smp();
    next_cyc(); smp();
    check("sim_d_first_cyc", bus_cyc_o, 1'b1);
    check("sim_d_first_addr", bus_addr_o, 32'h100);
    for (int k = 0; k < 3; k++) begin
      next_cyc(); smp();
      check("sim_d_wait_cyc", {bus_cyc_o, dm_ack_o, if_ack_o}, 3'b100);
    end
    next_cyc(); mem_wait = 0; smp();
    check("sim_d_ack", dm_ack_o, 1'b1);
    check("sim_d_rdata", dm_rdata_o, 32'h1234_5678);
    check("sim_d_stalls", {if_ack_o, stallreq_mem_o, stallreq_if_o, bus_cyc_o}, 4'b0010);
    next_cyc(); dm_req_i = 1'b0; smp();
    check("sim_i_next_cyc", bus_cyc_o, 1'b1);
    check("sim_i_next_addr", bus_addr_o, 32'h8);
    next_cyc(); smp();
    check("sim_i_ack", if_ack_o, 1'b1);
    check("sim_i_data", if_data_o, 32'hA5A5_0008);
    next_cyc(); if_req_i = 1'b0; smp();
    check("sim_idle", bus_cyc_o, 1'b0);

    // Store, bus fields held until ack; then fairness hands the tie to IF.
    next_cyc(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
    dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF; mem_wait = 2; smp();
    for (int k = 0; k < 3; k++) begin
      next_cyc(); smp();
      check("st_cyc", {bus_cyc_o, dm_ack_o}, 2'b10);
      check("st_we_sel", {bus_we_o, bus_sel_o}, 5'b1_0011);
      check("st_addr", bus_addr_o, 32'h200);
      check("st_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    end
    next_cyc(); smp();
    check("st_ack", dm_ack_o, 1'b1);
    check("st_rdata_zero", dm_rdata_o, 32'h0);
    next_cyc(); dm_req_i = 1'b0; dm_we_i = 1'b0; dm_wdata_i = '0; dm_sel_i = 4'hF; smp();
    check("st_idle", bus_cyc_o, 1'b0);
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'hC; dm_req_i = 1'b1; dm_addr_i = 32'h300; mem_wait = 0; smp();
    next_cyc(); smp();
    check("fair_i_addr", bus_addr_o, 32'hC);
    check("fair_i_we", bus_we_o, 1'b0);
    next_cyc(); smp();
    check("fair_i_ack", {if_ack_o, stallreq_mem_o}, 2'b11);
    check("fair_i_data", if_data_o, 32'hA5A5_000C);
    next_cyc(); if_req_i = 1'b0; smp();
    check("fair_d_cyc", bus_cyc_o, 1'b1);
    check("fair_d_addr", bus_addr_o, 32'h300);
    next_cyc(); smp();
    check("fair_d_ack", dm_ack_o, 1'b1);
    check("fair_d_rdata", dm_rdata_o, 32'hA5A5_0300);
    next_cyc(); dm_req_i = 1'b0; smp();

    // Flush in IDLE blocks the IF grant; flush in IBUSY drops the fetch.
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'h10; flush_i = 1'b1; smp();
    next_cyc(); flush_i = 1'b0; mem_wait = 4; smp();
    check("flush_idle_block", bus_cyc_o, 1'b0);
    next_cyc(); smp();
    check("flush_ibusy_addr", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h10});
    next_cyc(); flush_i = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b1; dm_addr_i = 32'h400; smp();
    check("flush_pulse_cyc", {bus_cyc_o, stallreq_mem_o}, 2'b11);
    next_cyc(); flush_i = 1'b0; smp();
    check("idrop_cyc", {bus_cyc_o, if_ack_o, dm_ack_o}, 3'b100);
    next_cyc(); smp();
    check("idrop_cyc2", {bus_cyc_o, if_ack_o}, 2'b10);
    next_cyc(); mem_wait = 0; smp();
    check("idrop_ackcyc", {bus_cyc_o, if_ack_o}, 2'b10);
    next_cyc(); smp();
    check("idrop_done", {bus_cyc_o, if_ack_o, dm_ack_o}, 3'b000);
    next_cyc(); smp();
    check("flush_d_next", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h400});
    next_cyc(); smp();
    check("flush_d_ack", {dm_ack_o, dm_rdata_o}, {1'b1, 32'hA5A5_0400});
    next_cyc(); dm_req_i = 1'b0; smp();

    // Watchdog: no ack, abort after exactly 8 busy cycles.
    next_cyc(); mem_hang = 1'b1; dm_req_i = 1'b1; dm_addr_i = 32'h500; smp();
    check("wd_err_before", bus_err_o, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      next_cyc(); smp();
      check("wd_busy", {bus_cyc_o, dm_ack_o, bus_err_o}, 3'b100);
    end
    next_cyc(); smp();
    check("wd_abort", {bus_cyc_o, dm_ack_o, bus_err_o}, 3'b011);
    check("wd_rdata_zero", dm_rdata_o, 32'h0);
    next_cyc(); dm_req_i = 1'b0; mem_hang = 1'b0; smp();
    check("wd_err_sticky", {bus_err_o, dm_ack_o}, 2'b10);
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'h14; smp();
    next_cyc(); smp();
    next_cyc(); smp();
    check("wd_after_if_ack", {if_ack_o, bus_err_o}, 2'b11);
    check("wd_after_if_data", if_data_o, 32'hA5A5_0014);
    next_cyc(); if_req_i = 1'b0; smp();

    // Reset mid-DBUSY, then a fresh tie goes to IF (last grant resets to D).
    next_cyc(); dm_req_i = 1'b1; dm_addr_i = 32'h600; mem_wait = 4; smp();
    next_cyc(); smp();
    check("rstmid_busy", bus_cyc_o, 1'b1);
    next_cyc(); rst = 1'b1; smp();
    check("rstmid_stall", stallreq_mem_o, 1'b0);
    next_cyc(); dm_req_i = 1'b0; smp();
    check("rstmid_outs", {bus_cyc_o, dm_ack_o, if_ack_o, bus_err_o, bus_we_o, bus_sel_o}, 9'h0);
    check("rstmid_addr", bus_addr_o, 32'h0);
    next_cyc(); rst = 1'b0; smp();
    check("rstmid_noack", {bus_cyc_o, dm_ack_o}, 2'b00);
    next_cyc(); if_req_i = 1'b1; if_addr_i = 32'h18; dm_req_i = 1'b1; dm_addr_i = 32'h700; mem_wait = 0; smp();
    next_cyc(); smp();
    check("post_rst_i_first", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h18});
    next_cyc(); smp();
    check("post_rst_i_ack", {if_ack_o, if_data_o}, {1'b1, 32'hA5A5_0018});
    next_cyc(); if_req_i = 1'b0; smp();
    check("post_rst_d_addr", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h700});
    next_cyc(); smp();
    check("post_rst_d_ack", {dm_ack_o, dm_rdata_o}, {1'b1, 32'hA5A5_0700});
    next_cyc(); dm_req_i = 1'b0; smp();
    check("post_rst_idle", {bus_cyc_o, bus_err_o}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
